// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts a captured pattern word out one bit per clock on x.
// Ports: clk/rst (async high); start,data,len request; x stream; busy,done status.
module serial_pattern_tx #(
  parameter int W          = 16,
  parameter int LW         = 5,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP        = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  data,
  input  logic [LW-1:0] len,
  output logic          x,
  output logic          busy,
  output logic          done
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_sh;
  logic [LW-1:0] r_cnt;
  logic [GW-1:0] r_gcnt;
  logic          r_x;
  logic          r_busy;
  logic          r_done;

  logic [LW-1:0] w_eff;
  logic [LW-1:0] w_shamt;
  logic [W-1:0]  w_load;
  logic          w_bit;
  logic [W-1:0]  w_next;

  // Lengths above W clamp silently to W.
  assign w_eff   = (len > LW'(W)) ? LW'(W) : len;

  // MSB-first: left-align the frame so bit eff_len-1 sits at the top.
  assign w_shamt = LW'(W) - w_eff;
  assign w_load  = MSB_FIRST ? (data << w_shamt) : data;
  assign w_bit   = MSB_FIRST ? r_sh[W-1] : r_sh[0];
  assign w_next  = MSB_FIRST ? {r_sh[W-2:0], 1'b0}
                             : {1'b0, r_sh[W-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_x     <= IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_x <= IDLE_LEVEL;
          if (start) begin
            if (w_eff == '0) begin
              r_done <= 1'b1;
            end else begin
              r_sh    <= w_load;
              r_cnt   <= w_eff;
              r_busy  <= 1'b1;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_x   <= w_bit;
            r_sh  <= w_next;
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_x <= IDLE_LEVEL;
            if (GAP > 0) begin
              r_gcnt  <= GW'(GAP);
              r_state <= S_GAP;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          r_x <= IDLE_LEVEL;
          if (r_gcnt <= GW'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt - 1'b1;
          end
        end
        default: begin
          r_x     <= IDLE_LEVEL;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign x    = r_x;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: two configurations (MSB/no gap, LSB/gap 2) on shared
// stimulus, checked against a frame-queue model plus directed sequences.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = '0;
  logic [4:0] len = '0;
  logic       xa, ba, da;
  logic       xb, bb, db;

  always #5 clk = ~clk;

  serial_pattern_tx #(
    .W(8), .LW(5), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b0)
  ) u_a (
    .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
    .x(xa), .busy(ba), .done(da)
  );

  serial_pattern_tx #(
    .W(8), .LW(5), .MSB_FIRST(1'b0), .GAP(2), .IDLE_LEVEL(1'b0)
  ) u_b (
    .clk(clk), .rst(rst), .start(start), .data(data), .len(len),
    .x(xb), .busy(bb), .done(db)
  );

  typedef struct packed {
    logic x;
    logic b;
    logic d;
  } exp_t;
  typedef exp_t eq_t[$];

  typedef struct {
    logic       st;
    logic [7:0] d;
    logic [4:0] l;
    logic [2:0] ex;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  eq_t         qa, qb;
  exp_t        ea, eb;
  logic [63:0] hist_a = '0;
  logic [63:0] hist_b = '0;
  vec_t        tv[11];
  int          nd_a, nd_b;

  function automatic exp_t mk(input logic x, input logic b, input logic d);
    exp_t e;
    e.x = x;
    e.b = b;
    e.d = d;
    return e;
  endfunction

  // Whole-frame expectation: one entry per cycle after each upcoming edge.
  function automatic eq_t build(input logic st, input logic [7:0] d,
                                input logic [4:0] l, input bit msb,
                                input int gap);
    eq_t r;
    int  eff;
    if (!st) begin
      r.push_back(mk(1'b0, 1'b0, 1'b0));
      return r;
    end
    if (l == 0) begin
      r.push_back(mk(1'b0, 1'b0, 1'b1));
      return r;
    end
    eff = (int'(l) > 8) ? 8 : int'(l);
    r.push_back(mk(1'b0, 1'b1, 1'b0));
    for (int k = 0; k < eff; k++)
      r.push_back(mk(msb ? d[eff-1-k] : d[k], 1'b1, 1'b0));
    for (int g = 0; g < gap; g++)
      r.push_back(mk(1'b0, 1'b1, 1'b0));
    r.push_back(mk(1'b0, 1'b0, 1'b1));
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [2:0] act,
                     input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got x/busy/done=%b required %b", nm, act, exp);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      qa.delete();
      qb.delete();
      ea = mk(1'b0, 1'b0, 1'b0);
      eb = mk(1'b0, 1'b0, 1'b0);
    end else begin
      if (qa.size() == 0) qa = build(start, data, len, 1'b1, 0);
      if (qb.size() == 0) qb = build(start, data, len, 1'b0, 2);
      ea = qa.pop_front();
      eb = qb.pop_front();
    end
    #1;
    cmp("model_a", {xa, ba, da}, ea);
    cmp("model_b", {xb, bb, db}, eb);
    hist_a = {hist_a[62:0], xa};
    hist_b = {hist_b[62:0], xb};
    if (da) nd_a++;
    if (db) nd_b++;
  endtask

  task automatic idle_steps(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tv[0]  = '{1'b1, 8'h8E, 5'd8, 3'b010};
    tv[1]  = '{1'b0, 8'h00, 5'd0, 3'b110};
    tv[2]  = '{1'b0, 8'h00, 5'd0, 3'b010};
    tv[3]  = '{1'b0, 8'h00, 5'd0, 3'b010};
    tv[4]  = '{1'b0, 8'h00, 5'd0, 3'b010};
    tv[5]  = '{1'b0, 8'h00, 5'd0, 3'b110};
    tv[6]  = '{1'b0, 8'h00, 5'd0, 3'b110};
    tv[7]  = '{1'b0, 8'h00, 5'd0, 3'b110};
    tv[8]  = '{1'b0, 8'h00, 5'd0, 3'b010};
    tv[9]  = '{1'b0, 8'h00, 5'd0, 3'b001};
    tv[10] = '{1'b0, 8'h00, 5'd0, 3'b000};

    #2;
    cmp("reset_a", {xa, ba, da}, 3'b000);
    cmp("reset_b", {xb, bb, db}, 3'b000);
    step();
    step();
    rst = 1'b0;
    idle_steps(2);

    // Table: 8E, len 8, MSB first on A.
    for (int i = 0; i < 11; i++) begin
      start = tv[i].st;
      data  = tv[i].d;
      len   = tv[i].l;
      step();
      cmp($sformatf("table_row%0d", i), {xa, ba, da}, tv[i].ex);
    end
    idle_steps(6);

    // len == 0: immediate single done, never busy.
    start = 1'b1; data = 8'hFF; len = 5'd0;
    step();
    cmp("len0_done_a", {xa, ba, da}, 3'b001);
    cmp("len0_done_b", {xb, bb, db}, 3'b001);
    start = 1'b0;
    step();
    cmp("len0_after_a", {xa, ba, da}, 3'b000);

    // len above W clamps to 8 bits.
    start = 1'b1; data = 8'hA5; len = 5'd12;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("clamp_bits_a", int'(hist_a[7:0]), 8'hA5);
    step();
    chk("clamp_done_a", int'(da), 1);
    idle_steps(6);

    // Second start during a frame is ignored.
    start = 1'b1; data = 8'hF0; len = 5'd8;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1; data = 8'h0F;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("ignore_bits_a", int'(hist_a[7:0]), 8'hF0);
    step();
    chk("ignore_done_a", int'(da), 1);
    nd_a = 0;
    idle_steps(12);
    chk("ignore_no_relaunch", nd_a, 0);

    // Reset after the third bit aborts with no done.
    start = 1'b1; data = 8'hF0; len = 5'd8;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pre_reset_bits", int'(hist_a[2:0]), 3'b111);
    #2;
    rst = 1'b1;
    #1;
    cmp("abort_a", {xa, ba, da}, 3'b000);
    cmp("abort_b", {xb, bb, db}, 3'b000);
    step();
    rst = 1'b0;
    nd_a = 0;
    nd_b = 0;
    idle_steps(14);
    chk("abort_no_done_a", nd_a, 0);
    chk("abort_no_done_b", nd_b, 0);

    // LSB first with a 2-cycle gap on B.
    start = 1'b1; data = 8'b0000_0110; len = 5'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    cmp("gap_busy_b", {xb, bb, db}, 3'b010);
    step();
    cmp("gap_done_b", {xb, bb, db}, 3'b001);
    chk("gap_bits_b", int'(hist_b[5:0]), 6'b011000);
    idle_steps(4);

    // Start held high: repeated frames.
    nd_a = 0;
    nd_b = 0;
    start = 1'b1; data = 8'h81; len = 5'd2;
    for (int i = 0; i < 12; i++) step();
    chk("held_bits_a", int'(hist_a[11:0]), 12'h222);
    chk("held_dones_a", nd_a, 3);
    chk("held_dones_b", nd_b, 2);
    idle_steps(10);

    // Random traffic against the frame model.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      data  = 8'($urandom);
      len   = 5'($urandom_range(0, 15));
      step();
    end
    idle_steps(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
